// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the serial link: receiver FSM states and the
// default word length agreed with the shift_register transmitter.
package shift_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/shift_deserializer.sv
// Frame-based serial-to-parallel receiver: a start strobe opens a frame,
// WIDTH valid LSB-first bits complete it and pulse out_valid for one cycle.
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_count
);

  state_t           state_reg, state_next;
  // Only the upper WIDTH-1 bits of the word are ever stored: the final bit
  // goes straight from ser_in into out, so bit 0 of a full-width shifter
  // would never be read.
  logic [WIDTH-2:0] shreg_reg, shreg_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      count_reg     <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      count_reg     <= count_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    shifted        = {ser_in, shreg_reg};
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    count_next     = count_reg;
    out_next       = out_reg;
    out_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RECV;
          shreg_next = '0;
          count_next = '0;
        end
      end
      RECV: begin
        // start wins even over a completing bit: that word is dropped.
        if (start) begin
          shreg_next = '0;
          count_next = '0;
        end else if (ser_valid) begin
          shreg_next = shifted[WIDTH-1:1];
          if (count_reg == CW'(WIDTH - 1)) begin
            out_next       = shifted;
            out_valid_next = 1'b1;
            state_next     = IDLE;
            count_next     = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg == RECV);
  assign bit_count = count_reg;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: hand-computed words, gaps, restarts,
// reset mid-frame and a behavioural right-shift transmitter loopback.
module tb_shift_deserializer;

  localparam int WIDTH = 8;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             ser_in;
  logic             ser_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;
  logic [CW-1:0]    bit_count;

  int tests  = 0;
  int errors = 0;
  logic [WIDTH-1:0] tx;

  shift_deserializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser_in    = b;
    ser_valid = 1'b1;
    tick();
    ser_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic open_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Transmitter model: load on the start cycle, present tx[0], shift right.
  task automatic tx_frame(input logic [WIDTH-1:0] w);
    tx    = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      ser_in    = tx[0];
      ser_valid = 1'b1;
      tick();
      tx = tx >> 1;
    end
    ser_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
    idle(2);
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_bit_count", 32'(bit_count), 32'h0);
    reset = 1'b0;

    // Basic word 0xA5: bits 1,0,1,0,0,1,0,1
    ser_valid = 1'b1; ser_in = 1'b1;
    open_frame();
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_ignores_bit", 32'(bit_count), 32'h0);
    ser_valid = 1'b0;
    send_bits(8'hA5, 7);
    chk("basic_count7", 32'(bit_count), 32'h7);
    chk("basic_no_early_pulse", 32'(out_valid), 32'h0);
    send_bit(1'b1);
    chk("basic_out", 32'(out), 32'hA5);
    chk("basic_pulse", 32'(out_valid), 32'h1);
    chk("basic_busy_after", 32'(busy), 32'h0);
    chk("basic_count_after", 32'(bit_count), 32'h0);
    tick();
    chk("basic_pulse_one_cycle", 32'(out_valid), 32'h0);
    chk("basic_out_held", 32'(out), 32'hA5);

    // Gapped 0xA5
    reset = 1'b1; tick(); reset = 1'b0;
    open_frame();
    send_bits(8'hA5, 2);
    idle(3);
    chk("gap1_count", 32'(bit_count), 32'h2);
    chk("gap1_no_pulse", 32'(out_valid), 32'h0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    idle(3);
    chk("gap2_count", 32'(bit_count), 32'h5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("gap_out", 32'(out), 32'hA5);
    chk("gap_pulse", 32'(out_valid), 32'h1);
    tick();
    chk("gap_single_pulse", 32'(out_valid), 32'h0);

    // Restart after 4 ones, then 0x3C
    open_frame();
    send_bits(8'hFF, 4);
    chk("restart_count4", 32'(bit_count), 32'h4);
    open_frame();
    chk("restart_count0", 32'(bit_count), 32'h0);
    chk("restart_busy", 32'(busy), 32'h1);
    chk("restart_no_pulse", 32'(out_valid), 32'h0);
    chk("restart_out_kept", 32'(out), 32'hA5);
    send_bits(8'h3C, 8);
    chk("restart_out", 32'(out), 32'h3C);
    chk("restart_pulse", 32'(out_valid), 32'h1);

    // Start together with the 8th bit
    open_frame();
    send_bits(8'h7F, 7);
    start = 1'b1; ser_in = 1'b1; ser_valid = 1'b1;
    tick();
    start = 1'b0; ser_valid = 1'b0;
    chk("final_start_no_pulse", 32'(out_valid), 32'h0);
    chk("final_start_out_kept", 32'(out), 32'h3C);
    chk("final_start_busy", 32'(busy), 32'h1);
    chk("final_start_count", 32'(bit_count), 32'h0);

    // Complete 0xA5 in the open frame, then reset mid-frame
    send_bits(8'hA5, 8);
    chk("pre_reset_out", 32'(out), 32'hA5);
    open_frame();
    send_bits(8'h1F, 5);
    chk("mid_count5", 32'(bit_count), 32'h5);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset_out", 32'(out), 32'h0);
    chk("midreset_out_valid", 32'(out_valid), 32'h0);
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_count", 32'(bit_count), 32'h0);
    send_bit(1'b1);
    chk("idle_bit_ignored", 32'(bit_count), 32'h0);
    chk("idle_stays_idle", 32'(busy), 32'h0);

    // Loopback from a right-shifting transmitter, then back-to-back frames
    tx_frame(8'h96);
    chk("loop_out", 32'(out), 32'h96);
    chk("loop_pulse", 32'(out_valid), 32'h1);
    tx_frame(8'h01);
    chk("b2b_01_out", 32'(out), 32'h01);
    chk("b2b_01_pulse", 32'(out_valid), 32'h1);
    tx_frame(8'hFF);
    chk("b2b_ff_out", 32'(out), 32'hFF);
    chk("b2b_ff_pulse", 32'(out_valid), 32'h1);
    tick();
    chk("b2b_end_pulse_low", 32'(out_valid), 32'h0);
    chk("b2b_end_idle", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
